// File: rtl/wb_host_pkg.sv
// Shared definitions for the Wishbone host master: FSM state encoding,
// the data word returned on a bus timeout, and Wishbone lane widths.
package wb_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_host_state_t;

    localparam logic [31:0] TIMEOUT_DATA  = 32'hDEADBEEF;
    localparam int          WB_SEL_WIDTH  = 4;
    localparam int          WB_DATA_WIDTH = 32;

endpackage

// File: rtl/wb_host_timeout.sv
// Bus-cycle watchdog for wb_host_master (only built with WB_HOST_TIMEOUT_EN).
// The counter is held at zero outside the bus phase, so it always starts
// from zero on entry. It advances once per bus cycle without ack, and
// 'expired' marks the TIMEOUT_CYCLES-th such cycle.
module wb_host_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [7:0] count;

    // Wait-cycle counter: cleared by reset or outside BUS, else counts stalls.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clear) begin
            count <= 8'd0;
        end else if (count_en && !expired) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_host_master.sv
// Single-outstanding-transfer Wishbone classic master driven by a
// valid/ready command port and returning a valid/ready response.
// Optional feature macro: WB_HOST_TIMEOUT_EN (bus timeout with error response).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload until that edge, and ready
// may depend on state only, never combinationally on valid.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    // command port
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [ADDR_WIDTH-1:0]    cmd_adr,
    input  logic [WB_DATA_WIDTH-1:0] cmd_dat,
    input  logic [WB_SEL_WIDTH-1:0]  cmd_sel,
    // response port
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WB_DATA_WIDTH-1:0] rsp_dat,
    output logic                     rsp_err,
    // Wishbone master
    output logic                     wbm_cyc_o,
    output logic                     wbm_stb_o,
    output logic                     wbm_we_o,
    output logic [WB_SEL_WIDTH-1:0]  wbm_sel_o,
    output logic [ADDR_WIDTH-1:0]    wbm_adr_o,
    output logic [WB_DATA_WIDTH-1:0] wbm_dat_o,
    input  logic                     wbm_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] wbm_dat_i,
    // debug visibility of the FSM
    output wb_host_state_t           state_dbg
);

    wb_host_state_t state;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cycles
        $error("wb_host_master: TIMEOUT_CYCLES must be within 2..255");
    end

`ifdef WB_HOST_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_count_en;
    logic tmo_expired;

    assign tmo_clear    = (state != ST_BUS);
    assign tmo_count_en = (state == ST_BUS) && !wbm_ack_i;

    wb_host_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clear    (tmo_clear),
        .count_en (tmo_count_en),
        .expired  (tmo_expired)
    );
`else
    assign rsp_err = 1'b0;
`endif

    assign state_dbg = state;

    // Transfer FSM; the captured command lives directly in the wbm_* registers,
    // which are zeroed whenever the cycle ends so the bus is quiet while idle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
`ifdef WB_HOST_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= cmd_we;
                        wbm_sel_o <= cmd_sel;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        state     <= ST_BUS;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_BUS: begin
                    // An ack in the expiry cycle still completes normally.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        wbm_adr_o <= '0;
                        wbm_dat_o <= '0;
                        rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
`ifdef WB_HOST_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
`ifdef WB_HOST_TIMEOUT_EN
                    else if (tmo_expired) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        wbm_adr_o <= '0;
                        wbm_dat_o <= '0;
                        rsp_dat   <= TIMEOUT_DATA;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed bench for wb_host_master: reset values, a table of single
// transfers, response backpressure, ack outside BUS and reset mid-transfer.
module tb_wb_host_master;
    import wb_host_pkg::*;

    localparam int AW = 32;

    // ---------------- clock / reset ----------------
    logic wb_clk_i = 1'b0;
    logic wb_rst_i;
    always #5 wb_clk_i = ~wb_clk_i;

    logic           cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0]  cmd_adr;
    logic [31:0]    cmd_dat;
    logic [3:0]     cmd_sel;
    logic           rsp_valid, rsp_ready, rsp_err;
    logic [31:0]    rsp_dat;
    logic           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [3:0]     wbm_sel_o;
    logic [AW-1:0]  wbm_adr_o;
    logic [31:0]    wbm_dat_o, wbm_dat_i;
    wb_host_state_t state_dbg;

    wb_host_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    // ack_delay: bus cycles before ack (0 = ack in first BUS cycle, -1 = never)
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_delay;
        logic [31:0] slave_dat;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[6];
    int   n_vecs;

    // ---------------- driver tasks ----------------
    task automatic run_vec(input vec_t v, input string tag);
        int          waited;
        int          cyc_cnt;
        logic        stable_ok;
        logic [31:0] exp_dat;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge wb_clk_i);
            waited++;
        end
        check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        exp_q.push_back(v.exp_dat);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        check({tag, " cyc"}, 32'(wbm_cyc_o), 32'd1);
        check({tag, " stb"}, 32'(wbm_stb_o), 32'd1);
        check({tag, " we"},  32'(wbm_we_o),  32'(v.we));
        check({tag, " adr"}, wbm_adr_o,      v.adr);
        check({tag, " dat_o"}, wbm_dat_o,    v.dat);
        check({tag, " sel"}, 32'(wbm_sel_o), 32'(v.sel));
        cyc_cnt   = 0;
        stable_ok = 1'b1;
        while (wbm_cyc_o && cyc_cnt < 300) begin
            cyc_cnt++;
            if (wbm_adr_o !== v.adr || wbm_dat_o !== v.dat || wbm_sel_o !== v.sel ||
                wbm_we_o !== v.we || wbm_stb_o !== 1'b1)
                stable_ok = 1'b0;
            if (cyc_cnt == v.ack_delay + 1) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = v.slave_dat;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = 32'h0;
            end
            @(negedge wb_clk_i);
        end
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        exp_dat = exp_q.pop_front();
        check({tag, " bus stable"}, 32'(stable_ok), 32'd1);
        check({tag, " cyc cycles"}, 32'(cyc_cnt), 32'(v.exp_cyc));
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rsp_dat"}, rsp_dat, exp_dat);
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        check({tag, " idle bus"}, {wbm_dat_o[31:1] | wbm_adr_o[31:1],
              wbm_dat_o[0] | wbm_adr_o[0] | wbm_we_o | wbm_stb_o | (|wbm_sel_o)}, 32'd0);
        check({tag, " state resp"}, 32'(state_dbg), 32'(ST_RESP));
        check({tag, " cmd_ready in resp"}, 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        check({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
        check({tag, " cmd_ready back"}, 32'(cmd_ready), 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic stay_quiet;
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = '0;

        vecs[0] = '{we:1'b0, adr:32'h30000004, dat:32'h0, sel:4'hF, ack_delay:1,
                    slave_dat:32'h4669626F, exp_dat:32'h4669626F, exp_err:1'b0, exp_cyc:2};
        vecs[1] = '{we:1'b1, adr:32'h30000018, dat:32'h12345678, sel:4'hF, ack_delay:1,
                    slave_dat:32'hAAAA5555, exp_dat:32'h0, exp_err:1'b0, exp_cyc:2};
        vecs[2] = '{we:1'b0, adr:32'h00000010, dat:32'h0, sel:4'h3, ack_delay:0,
                    slave_dat:32'h0BADF00D, exp_dat:32'h0BADF00D, exp_err:1'b0, exp_cyc:1};
        vecs[3] = '{we:1'b1, adr:32'hFFFFFFFC, dat:32'hA5A5A5A5, sel:4'h5, ack_delay:3,
                    slave_dat:32'h77777777, exp_dat:32'h0, exp_err:1'b0, exp_cyc:4};
`ifdef WB_HOST_TIMEOUT_EN
        vecs[4] = '{we:1'b0, adr:32'h30000100, dat:32'h0, sel:4'hF, ack_delay:-1,
                    slave_dat:32'h0, exp_dat:32'hDEADBEEF, exp_err:1'b1, exp_cyc:16};
        vecs[5] = '{we:1'b0, adr:32'h30000104, dat:32'h0, sel:4'hF, ack_delay:15,
                    slave_dat:32'h13579BDF, exp_dat:32'h13579BDF, exp_err:1'b0, exp_cyc:16};
        n_vecs = 6;
`else
        vecs[4] = '{we:1'b0, adr:32'h30000200, dat:32'h0, sel:4'hF, ack_delay:99,
                    slave_dat:32'h00000008, exp_dat:32'h00000008, exp_err:1'b0, exp_cyc:100};
        vecs[5] = vecs[4];
        n_vecs = 5;
`endif

        // reset values
        repeat (3) @(negedge wb_clk_i);
        check("reset cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_err",   32'(rsp_err),   32'd0);
        check("reset rsp_dat",   rsp_dat,        32'd0);
        check("reset cyc/stb/we", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
        check("reset adr",       wbm_adr_o,      32'd0);
        check("reset dat_o",     wbm_dat_o,      32'd0);
        check("reset sel",       32'(wbm_sel_o), 32'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("cmd_ready after release", 32'(cmd_ready), 32'd1);
        check("state idle", 32'(state_dbg), 32'(ST_IDLE));

        // ack while idle is ignored
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hFFFFFFFF;
        repeat (3) @(negedge wb_clk_i);
        check("idle ack rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle ack cyc", 32'(wbm_cyc_o), 32'd0);
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;

        // table-driven transfers
        for (int i = 0; i < n_vecs; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // response backpressure with a second command waiting
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h30000008;
        cmd_sel   = 4'hF;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        check("bp cyc", 32'(wbm_cyc_o), 32'd1);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h55AA33CC;
        @(negedge wb_clk_i);
        check("bp rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp rsp_dat", rsp_dat, 32'h55AA33CC);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h30000020;
        cmd_dat   = 32'hCAFEF00D;
        cmd_sel   = 4'hC;
        wbm_dat_i = 32'h11111111;
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i);
            check("bp hold rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp hold rsp_dat", rsp_dat, 32'h55AA33CC);
            check("bp hold cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp hold cyc", 32'(wbm_cyc_o), 32'd0);
        end
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        check("bp handshake rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp not accepted at handshake", 32'(wbm_cyc_o), 32'd0);
        check("bp cmd_ready after handshake", 32'(cmd_ready), 32'd1);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        check("bp second cyc", 32'(wbm_cyc_o), 32'd1);
        check("bp second we", 32'(wbm_we_o), 32'd1);
        check("bp second dat_o", wbm_dat_o, 32'hCAFEF00D);
        check("bp second sel", 32'(wbm_sel_o), 32'hC);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h22222222;
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        check("bp second rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp second rsp_dat", rsp_dat, 32'h0);
        check("bp second rsp_err", 32'(rsp_err), 32'd0);
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;

        // reset pulsed mid-transfer
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h30000040;
        cmd_sel   = 4'hF;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        check("rst mid cyc before", 32'(wbm_cyc_o), 32'd1);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        check("rst mid cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst mid stb", 32'(wbm_stb_o), 32'd0);
        check("rst mid adr", wbm_adr_o, 32'd0);
        check("rst mid cmd_ready", 32'(cmd_ready), 32'd0);
        stay_quiet = 1'b1;
        wbm_ack_i  = 1'b1;
        wbm_dat_i  = 32'h99999999;
        repeat (3) begin
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) stay_quiet = 1'b0;
            @(negedge wb_clk_i);
        end
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        check("rst mid no response", 32'(stay_quiet), 32'd1);
        run_vec(vecs[0], "after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
